// File: rtl/ptr_fetch_if.sv
// ptr_fetch_if: controller handshake and register-file read bus of the pointer fetch unit.
// Rev 1.0
`default_nettype none

interface ptr_fetch_if #(
  parameter int DATA_W = 16,
  parameter int TAP_W  = 8,
  parameter int RAM_AW = 10,
  parameter int RF_AW  = 6,
  parameter int IDX_W  = 4
) ();
  logic              en;
  logic              en_fetch;
  logic              ptrs_req;
  logic              idx_clr;
  logic              rf_rd_en;
  logic [RF_AW-1:0]  rf_addr;
  logic [DATA_W-1:0] rf_rd_data;
  logic              req_complete;
  logic              iw_valid;
  logic [TAP_W-1:0]  tap_count;
  logic [RAM_AW-1:0] smp_ptr;
  logic [RAM_AW-1:0] coef_ptr;
  logic [IDX_W-1:0]  struct_idx;

  // Controller / register-file side
  modport master (
    output en, en_fetch, ptrs_req, idx_clr, rf_rd_data,
    input  rf_rd_en, rf_addr, req_complete, iw_valid, tap_count, smp_ptr, coef_ptr, struct_idx
  );

  // Fetch unit side
  modport slave (
    input  en, en_fetch, ptrs_req, idx_clr, rf_rd_data,
    output rf_rd_en, rf_addr, req_complete, iw_valid, tap_count, smp_ptr, coef_ptr, struct_idx
  );
endinterface

`default_nettype wire

// File: rtl/ptr_fetch.sv
// ptr_fetch: reads 3-word pointer structs from the register file and decodes them for the upsampler.
// Rev 1.0
`default_nettype none

module ptr_fetch #(
  parameter int NUM_STRUCTS = 16,
  parameter int DATA_W      = 16,
  parameter int TAP_W       = 8,
  parameter int RAM_AW      = 10,
  parameter int RF_AW       = 6
) (
  input  logic         clk,
  input  logic         rst_n,
  ptr_fetch_if.slave   bus
);

  localparam int IDX_W = (NUM_STRUCTS > 1) ? $clog2(NUM_STRUCTS) : 1;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_ISS0 = 3'd1;
  localparam logic [2:0] S_ISS1 = 3'd2;
  localparam logic [2:0] S_ISS2 = 3'd3;
  localparam logic [2:0] S_CAPT = 3'd4;
  localparam logic [2:0] S_DONE = 3'd5;

  logic [2:0]        r_state;
  logic [2:0]        w_next;
  logic              w_start;
  logic              w_abort;
  logic              w_issue;
  logic [RF_AW-1:0]  w_k;
  logic [RF_AW-1:0]  w_base;

  logic [IDX_W-1:0]  r_idx;
  logic              r_w0_valid;
  logic              r_w0_last;
  logic [TAP_W-1:0]  r_w0_tap;
  logic [RAM_AW-1:0] r_smp_cap;
  logic              r_iw_valid;
  logic [TAP_W-1:0]  r_tap;
  logic [RAM_AW-1:0] r_smp;
  logic [RAM_AW-1:0] r_coef;

  assign w_start = bus.en && bus.en_fetch && bus.ptrs_req;
  assign w_abort = !bus.en || bus.idx_clr;
  assign w_base  = RF_AW'({r_idx, 1'b0}) + RF_AW'(r_idx);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (w_start) w_next = S_ISS0;
      S_ISS0: w_next = w_abort ? S_IDLE : S_ISS1;
      S_ISS1: w_next = w_abort ? S_IDLE : S_ISS2;
      S_ISS2: w_next = w_abort ? S_IDLE : S_CAPT;
      S_CAPT: w_next = w_abort ? S_IDLE : S_DONE;
      S_DONE: if (bus.en) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_issue = 1'b0;
    w_k     = '0;
    case (r_state)
      S_ISS0: begin w_issue = 1'b1; w_k = RF_AW'(0); end
      S_ISS1: begin w_issue = 1'b1; w_k = RF_AW'(1); end
      S_ISS2: begin w_issue = 1'b1; w_k = RF_AW'(2); end
      default: ;
    endcase
  end

  assign bus.rf_rd_en     = w_issue && bus.en;
  assign bus.rf_addr      = w_issue ? (w_base + w_k) : '0;
  assign bus.req_complete = (r_state == S_DONE);

  // Read data trails the strobe by one cycle, so word k lands in the state after ISSk.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx      <= '0;
      r_w0_valid <= 1'b0;
      r_w0_last  <= 1'b0;
      r_w0_tap   <= '0;
      r_smp_cap  <= '0;
      r_iw_valid <= 1'b0;
      r_tap      <= '0;
      r_smp      <= '0;
      r_coef     <= '0;
    end else if (bus.en) begin
      if (r_state == S_IDLE && bus.en_fetch && bus.ptrs_req) begin
        r_iw_valid <= 1'b0;
      end
      if (bus.idx_clr) begin
        r_idx <= '0;
      end else if (r_state == S_DONE) begin
        r_idx <= (r_w0_last || r_idx == IDX_W'(NUM_STRUCTS - 1)) ? '0 : r_idx + IDX_W'(1);
      end
      case (r_state)
        S_ISS1: begin
          r_w0_valid <= bus.rf_rd_data[DATA_W-1];
          r_w0_last  <= bus.rf_rd_data[DATA_W-2];
          r_w0_tap   <= bus.rf_rd_data[TAP_W-1:0];
        end
        S_ISS2: r_smp_cap <= bus.rf_rd_data[RAM_AW-1:0];
        S_CAPT: begin
          if (!bus.idx_clr) begin
            r_tap      <= r_w0_tap;
            r_smp      <= r_smp_cap;
            r_coef     <= bus.rf_rd_data[RAM_AW-1:0];
            r_iw_valid <= r_w0_valid && (r_w0_tap != '0);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.iw_valid   = r_iw_valid;
  assign bus.tap_count  = r_tap;
  assign bus.smp_ptr    = r_smp;
  assign bus.coef_ptr   = r_coef;
  assign bus.struct_idx = r_idx;

endmodule

`default_nettype wire

// File: doc/ptr_fetch.md
Name: ptr_fetch

Overview:
- Pointer-struct fetch unit directly upstream of the upsampling controller FSM.
- Serves the controller's `en_fetch`/`ptrs_req` request by reading one 3-word pointer struct from the pointer register file.
- Decodes the struct into tap count, sample-RAM pointer and coefficient-RAM pointer, and returns `req_complete`/`iw_valid` to the controller.
- Walks a circular table of structs; wraps on the `last` flag or at the table end.

Parameters:
- NUM_STRUCTS, 16, number of pointer structs in the table (>=1).
- DATA_W, 16, register-file word width.
- TAP_W, 8, tap-count field width (TAP_W <= 14).
- RAM_AW, 10, data-RAM address width (RAM_AW <= DATA_W).
- RF_AW, 6, register-file address width (must satisfy 3*NUM_STRUCTS <= 2^RF_AW).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- en  in  1  clock enable, shared with the controller.
- en_fetch  in  1  fetch enable from the controller.
- ptrs_req  in  1  next-struct request from the controller.
- idx_clr  in  1  synchronous clear of the struct index.
- rf_rd_en  out  1  register-file read strobe.
- rf_addr  out  RF_AW  register-file read address.
- rf_rd_data  in  DATA_W  read data; valid exactly 1 cycle after `rf_rd_en`.
- req_complete  out  1  one-cycle pulse: struct fetched.
- iw_valid  out  1  fetched struct is usable.
- tap_count  out  TAP_W  taps for this output sample.
- smp_ptr  out  RAM_AW  sample-RAM base pointer.
- coef_ptr  out  RAM_AW  coefficient-RAM base pointer.
- struct_idx  out  ceil(log2(NUM_STRUCTS)), min 1  index of the struct being or last fetched.

Behaviour:
- Reset: one clock; reset is asynchronous and active-low on `rst_n`. All outputs, the state and internal captures reset to 0; state = IDLE.
- Struct layout at rf_addr = 3*idx + k:
  - k=0: bit DATA_W-1 = valid, bit DATA_W-2 = last, [TAP_W-1:0] = tap_count.
  - k=1: [RAM_AW-1:0] = smp_ptr.
  - k=2: [RAM_AW-1:0] = coef_ptr.
- States and transitions (all transitions gated by `en`):
  - IDLE: leave when `en_fetch && ptrs_req`.
  - ISSUE: k=0..2, 3 cycles.
  - CAPT: 1 cycle.
  - DONE: 1 cycle, then IDLE.
- Timing, with the request sampled in IDLE during cycle 0:
  - `rf_rd_en`=1 in cycles 1,2,3 with `rf_addr` = 3*idx+0, +1, +2.
  - Word 0 captured at the end of cycle 2, word 1 at the end of cycle 3, word 2 at the end of cycle 4.
  - DONE in cycle 5: `req_complete`=1 for exactly that cycle.
- `iw_valid` and the field outputs:
  - `iw_valid` is cleared in cycle 1.
  - It is set with word 0's valid bit AND (tap_count != 0); it becomes visible in cycle 5 together with the fields.
  - All outputs are registered.
  - Fields and `iw_valid` hold until the next fetch starts.
- Index advance, in DONE:
  - idx <= 0 if the last bit is set or idx == NUM_STRUCTS-1.
  - Otherwise idx <= idx+1.
  - The index advances regardless of `iw_valid`, so an invalid struct is skipped: the controller keeps `ptrs_req` high and the next fetch starts from IDLE one cycle after DONE.
- `ptrs_req` deasserting mid-fetch: the fetch completes normally and `req_complete` still pulses.
- `en`=0:
  - In IDLE or DONE: state, idx and outputs are frozen. `req_complete` stays high while DONE is frozen.
  - In ISSUE or CAPT: the fetch aborts to IDLE, idx is unchanged, `iw_valid` stays 0, `rf_rd_en`=0. The struct is refetched from word 0 once `en`=1 and the request is present.
- `rf_rd_en` is 0 whenever `en`=0.
- `idx_clr`: sets idx to 0 and has priority over the DONE advance.
  - In ISSUE or CAPT: also aborts to IDLE.
  - In DONE: `req_complete` still pulses, but idx goes to 0.
- `rst_n` asserted mid-fetch: immediate asynchronous return to the reset values; no pulse is emitted.

Test Plan:
1. After reset, struct 0 = {valid=1, last=0, tap=24}, smp=0x010, coef=0x200. Hold `en_fetch`=`ptrs_req`=1 → `rf_rd_en` in cycles 1-3 at addr 0,1,2; cycle 5: `req_complete`=1, `iw_valid`=1, tap_count=24, smp_ptr=0x010, coef_ptr=0x200; `struct_idx` becomes 1.
2. Struct 1 has valid=0, struct 2 is valid, `ptrs_req` held high → pulse with `iw_valid`=0 for idx 1; a second fetch at addr 6-8 begins the cycle after DONE; second pulse with `iw_valid`=1.
3. Struct 3 has last=1 → after its DONE, `struct_idx`=0. Separately, NUM_STRUCTS=4 with no last flags → idx wraps from 3 to 0.
4. Drop `en` in cycle 2 for 3 cycles → no `req_complete`; refetch restarts at word 0 of the same idx; completes 5 cycles after resume with correct fields.
5. Pulse `idx_clr` during ISSUE at idx=5 → abort; next fetch reads addr 0-2. `idx_clr` in DONE → pulse occurs and idx=0.
6. Assert `rst_n`=0 asynchronously in CAPT → all outputs 0 immediately, no pulse; after release the first fetch reads addr 0.
